img_sram_arbiter: RTL and testbench

IMG_SRAM_ARBITER -- requirements
Module: img_sram_arbiter

---
 rtl/img_sram_arbiter.sv | 130 +++++++++++++
 tb/tb_img_sram_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/img_sram_arbiter.sv
// Round-robin arbiter giving NREQ requesters single-transaction access to three image SRAM banks.
// Each transaction is IDLE -> ISSUE -> CAPT -> RESP, so one request is accepted at most every 4 cycles.
module img_sram_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 21,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    input  logic [NREQ*4-1:0]    req_be,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [DW-1:0]        rsp_rdata,
    output logic                 rsp_err,
    output logic [2:0]           bank_en,
    output logic [3:0]           bank_we,
    output logic [16:0]          bank_addr,
    output logic [DW-1:0]        bank_wdata,
    input  logic [DW-1:0]        bank_rdata0,
    input  logic [DW-1:0]        bank_rdata1,
    input  logic [DW-1:0]        bank_rdata2
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;
    state_t state, next_state;

    logic [IW-1:0] last_grant, winner, pick, cand;
    logic          found, accept;
    logic          lat_we, dec_err;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [3:0]    lat_be;
    logic [1:0]    bank;

    assign bank = lat_addr[AW-1 -: 2];

    // Search starts one past the last grant so a continuously busy requester cannot starve the rest.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_grant) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign accept = (state == IDLE) && found && !rst;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        req_ready  = '0;
        rsp_valid  = '0;
        bank_en    = '0;
        bank_we    = '0;
        bank_addr  = lat_addr[18:2];
        bank_wdata = lat_wdata;
        case (state)
            IDLE: begin
                if (accept) begin
                    req_ready[pick] = 1'b1;
                    next_state      = ISSUE;
                end
            end
            ISSUE: begin
                if (bank != 2'b11) begin
                    bank_en[bank] = 1'b1;
                    bank_we       = lat_we ? lat_be : 4'b0000;
                end
                next_state = CAPT;
            end
            CAPT: next_state = RESP;
            RESP: begin
                rsp_valid[winner] = 1'b1;
                if (rsp_ready[winner]) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= IW'(NREQ - 1);
            winner     <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_be     <= '0;
            dec_err    <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                winner     <= pick;
                last_grant <= pick;
                lat_we     <= req_we[pick];
                lat_addr   <= req_addr[int'(pick)*AW +: AW];
                lat_wdata  <= req_wdata[int'(pick)*DW +: DW];
                lat_be     <= req_be[int'(pick)*4 +: 4];
            end
            if (state == ISSUE) dec_err <= (bank == 2'b11);
            // Bank read data arrives the cycle after bank_en, i.e. during CAPT.
            if (state == CAPT) begin
                rsp_err <= dec_err;
                if (lat_we || dec_err) rsp_rdata <= '0;
                else begin
                    case (bank)
                        2'd0:    rsp_rdata <= bank_rdata0;
                        2'd1:    rsp_rdata <= bank_rdata1;
                        default: rsp_rdata <= bank_rdata2;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_img_sram_arbiter.sv
// Directed bench for img_sram_arbiter: a vector table of single transactions plus
// round-robin, response-stall and mid-transaction reset sequences.
module tb_img_sram_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 21;
    localparam int DW   = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid, req_ready, req_we, rsp_valid, rsp_ready;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_wdata;
    logic [NREQ*4-1:0]   req_be;
    logic [DW-1:0]       rsp_rdata, bank_wdata, bank_rdata0, bank_rdata1, bank_rdata2;
    logic                rsp_err;
    logic [2:0]          bank_en;
    logic [3:0]          bank_we;
    logic [16:0]         bank_addr;

    int checks = 0;
    int errors = 0;

    img_sram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr), .bank_wdata(bank_wdata),
        .bank_rdata0(bank_rdata0), .bank_rdata1(bank_rdata1), .bank_rdata2(bank_rdata2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          r;
        logic        we;
        logic [20:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic [2:0]  exp_en;
        logic [3:0]  exp_we;
        logic [16:0] exp_baddr;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_req(input int r, input logic we, input logic [20:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be);
        req_valid          = '0;
        req_valid[r]       = 1'b1;
        req_we[r]          = we;
        req_addr[r*AW +: AW] = addr;
        req_wdata[r*DW +: DW] = wdata;
        req_be[r*4 +: 4]   = be;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        logic [2:0] oh;
        v  = vecs[i];
        oh = 3'(1 << v.r);
        @(negedge clk);
        drive_req(v.r, v.we, v.addr, v.wdata, v.be);
        bank_rdata0 = (v.addr[20:19] == 2'd0) ? v.rdata : 32'hBAD0_0000;
        bank_rdata1 = (v.addr[20:19] == 2'd1) ? v.rdata : 32'hBAD0_0001;
        bank_rdata2 = (v.addr[20:19] == 2'd2) ? v.rdata : 32'hBAD0_0002;
        rsp_ready = '0;
        #1;
        chk($sformatf("v%0d req_ready T", i), 32'(req_ready), 32'(oh));
        chk($sformatf("v%0d bank_en T", i), 32'(bank_en), 32'd0);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk($sformatf("v%0d bank_en T+1", i), 32'(bank_en), 32'(v.exp_en));
        chk($sformatf("v%0d bank_we T+1", i), 32'(bank_we), 32'(v.exp_we));
        if (v.exp_en != 3'b000) chk($sformatf("v%0d bank_addr", i), 32'(bank_addr), 32'(v.exp_baddr));
        if (v.we) chk($sformatf("v%0d bank_wdata", i), bank_wdata, v.wdata);
        @(negedge clk);
        #1;
        chk($sformatf("v%0d bank_en T+2", i), 32'(bank_en), 32'd0);
        chk($sformatf("v%0d rsp_valid T+2", i), 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        chk($sformatf("v%0d rsp_valid T+3", i), 32'(rsp_valid), 32'(oh));
        chk($sformatf("v%0d rsp_rdata", i), rsp_rdata, v.exp_rd);
        chk($sformatf("v%0d rsp_err", i), 32'(rsp_err), 32'(v.exp_err));
        rsp_ready = oh;
        @(negedge clk);
        #1;
        chk($sformatf("v%0d rsp_valid done", i), 32'(rsp_valid), 32'd0);
        rsp_ready = '0;
    endtask

    initial begin
        logic [2:0] grants[6];
        logic [2:0] exp_rr[6];
        int ng;

        vecs[0] = '{0, 1'b0, 21'h080010, 32'h0, 4'hF, 32'hDEADBEEF, 3'b010, 4'b0000, 17'h00004, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{1, 1'b1, 21'h100000, 32'h12345678, 4'b0011, 32'h55AA55AA, 3'b100, 4'b0011, 17'h00000, 32'h0, 1'b0};
        vecs[2] = '{2, 1'b0, 21'h180000, 32'h0, 4'hF, 32'h11111111, 3'b000, 4'b0000, 17'h00000, 32'h0, 1'b1};
        vecs[3] = '{0, 1'b0, 21'h000FFC, 32'h0, 4'hF, 32'hA5A5_0FF0, 3'b001, 4'b0000, 17'h003FF, 32'hA5A5_0FF0, 1'b0};
        vecs[4] = '{1, 1'b1, 21'h1FFFFC, 32'hFFFF0000, 4'hF, 32'h22222222, 3'b000, 4'b0000, 17'h00000, 32'h0, 1'b1};
        vecs[5] = '{2, 1'b0, 21'h17FFFC, 32'h0, 4'hF, 32'h0BADF00D, 3'b100, 4'b0000, 17'h1FFFF, 32'h0BADF00D, 1'b0};
        exp_rr = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

        rst = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
        rsp_ready = '0;
        bank_rdata0 = 32'h0; bank_rdata1 = 32'h0; bank_rdata2 = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        chk("reset bank_en", 32'(bank_en), 32'd0);
        chk("reset bank_we", 32'(bank_we), 32'd0);
        rst = 1'b0;

        // Round robin with all requesters permanently valid.
        @(negedge clk);
        req_valid = 3'b111;
        rsp_ready = 3'b111;
        ng = 0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            #1;
            if (req_ready != 3'b000) begin
                grants[ng] = req_ready;
                ng++;
            end
            if (ng < 6) @(negedge clk);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        chk("rr grant count", 32'(ng), 32'd6);
        for (int g = 0; g < ng; g++) chk($sformatf("rr grant %0d", g), 32'(grants[g]), 32'(exp_rr[g]));
        repeat (5) @(negedge clk);
        rsp_ready = '0;

        for (int i = 0; i < 6; i++) run_vec(i);

        // Response stall: data must hold and requester 1 must wait.
        @(negedge clk);
        drive_req(0, 1'b0, 21'h080020, 32'h0, 4'hF);
        bank_rdata1 = 32'hCAFEF00D;
        #1;
        chk("stall req_ready T", 32'(req_ready), 32'b001);
        @(negedge clk);
        req_valid = 3'b010;
        #1;
        chk("stall req_ready ISSUE", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("stall req_ready CAPT", 32'(req_ready), 32'd0);
        @(negedge clk);
        bank_rdata1 = 32'h0;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk($sformatf("stall %0d rsp_valid", s), 32'(rsp_valid), 32'b001);
            chk($sformatf("stall %0d rsp_rdata", s), rsp_rdata, 32'hCAFEF00D);
            chk($sformatf("stall %0d req_ready", s), 32'(req_ready), 32'd0);
            if (s < 4) @(negedge clk);
        end
        rsp_ready = 3'b001;
        @(negedge clk);
        #1;
        chk("stall release rsp_valid", 32'(rsp_valid), 32'd0);
        chk("stall release req_ready", 32'(req_ready), 32'b010);
        req_valid = '0;
        rsp_ready = '0;

        // Reset in CAPT aborts the transaction and restores requester-0 priority.
        @(negedge clk);
        drive_req(1, 1'b0, 21'h000004, 32'h0, 4'hF);
        bank_rdata0 = 32'h77777777;
        #1;
        chk("rstcapt req_ready T", 32'(req_ready), 32'b010);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rstcapt rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstcapt rsp_rdata", rsp_rdata, 32'd0);
        chk("rstcapt rsp_err", 32'(rsp_err), 32'd0);
        chk("rstcapt bank_en", 32'(bank_en), 32'd0);
        chk("rstcapt bank_we", 32'(bank_we), 32'd0);
        chk("rstcapt req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        rsp_ready = 3'b111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rstcapt quiet %0d rsp_valid", c), 32'(rsp_valid), 32'd0);
            chk($sformatf("rstcapt quiet %0d bank_en", c), 32'(bank_en), 32'd0);
        end
        req_valid = 3'b111;
        #1;
        chk("rstcapt next grant", 32'(req_ready), 32'b001);
        req_valid = '0;
        rsp_ready = '0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
